mdio_master_q: RTL and testbench
================================

// Module: mdio_master_q
// PURPOSE
//  Parametrised MDIO management master for Ethernet PHYs, next generation of the per-PHY MDIO logic.
//  Adds a command FIFO, configurable MDC rate and preamble length, an inter-frame gap and sticky error flags.
//  Sits between the register bus (upper address decode external) and the PHY MDC/MDIO pins or a GMII-to-RGMII core.
// PARAMETERS
//  CLK_DIV        8   MDC half-period in clk cycles (>=2); MDC period = 2*CLK_DIV clk
//  PREAMBLE_BITS  32  preamble ones sent before ST (0 = suppression, 1..32 allowed)
//  FIFO_DEPTH     4   command FIFO entries, power of 2 (2..16)
// PORTS
//  clk           in   1   system clock
//  rstn          in   1   reset, synchronous, active-low
//  reg_waddr     in   16  write address; only [7:0] decoded here
//  reg_wdata     in   32  write data (MDIO command frame after preamble)
//  reg_wen       in   1   write enable
//  reg_raddr     in   16  read address; only [7:0] decoded here
//  reg_rdata     out  32  read data (combinational from reg_raddr)
//  MDC           out  1   management clock to PHY
//  MDIO_I        in   1   data from PHY
//  MDIO_O        out  1   data to PHY
//  MDIO_T        out  1   tristate, 1 = release line
//  frame_done    out  1   1-clk pulse when a frame completes (write or read)
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): MDC=0, MDIO_O=1, MDIO_T=1, frame_done=0, state IDLE, FIFO flushed,
//    read_data=0, read_reg_addr=0, overflow=0, st_err=0. Reset mid-frame aborts immediately; no partial bits follow.
//  Push: reg_wen && reg_waddr[7:0]==8'h00 writes reg_wdata to FIFO. FIFO full -> command dropped, overflow set.
//  Clear: reg_wen && reg_waddr[7:0]==8'h01 clears overflow and st_err; a same-cycle set wins over clear.
//  Reads: 8'h80 -> {busy,fifo_full,fifo_empty,overflow,st_err,state[2:0],3'd0,read_reg_addr[4:0],read_data[15:0]};
//    8'h81 -> {27'd0, fifo_level[4:0]}; any other -> 32'd0.
//  busy = (state != IDLE).
//  Timing: divider div_cnt runs 0..2*CLK_DIV-1 only outside IDLE; MDC=0 for 0..CLK_DIV-1, 1 otherwise.
//    MDIO_O changes at div_cnt==1 (setup CLK_DIV-1 clk before rising MDC); read sample at div_cnt==CLK_DIV-1.
//  States:
//    IDLE: MDC=0, MDIO_T=1; if FIFO non-empty pop head (FIFO must not be empty), latch cmd, div_cnt=0,
//      MDIO_T=0, MDIO_O=1 -> PREAMBLE (PREAMBLE_BITS>0) else FRAME. Illegal ST -> drop, set st_err, stay IDLE.
//    PREAMBLE: PREAMBLE_BITS MDC periods of MDIO_O=1 -> FRAME.
//    FRAME: bits cmd[31] first. Write/address op: all 32 bits -> GAP. Read op: 14 bits (ST,OP,PHYAD,REGAD) -> READ_TA.
//    READ_TA: MDIO_T=1 at div_cnt==1 of first TA bit; 2 periods; latch read_reg_addr=cmd[22:18] -> READ_DATA.
//    READ_DATA: 16 periods, shift MDIO_I MSB-first into read_data (updates only at the sample point) -> GAP.
//    GAP: MDIO_T=1, one MDC period; frame_done pulses on the last clk of GAP -> IDLE.
//  Frame length, clause 22 write: (PREAMBLE_BITS+32+1)*2*CLK_DIV clk from pop to frame_done.
//  Back-to-back commands: next pop one clk after GAP->IDLE; FIFO push while busy always queued.
//  Simultaneous push and pop on full FIFO: pop first, push accepted, no overflow.
//  Clause 22 ST=2'b01: OP 01 write, 10 read. OP 00/11 with ST=01 -> st_err, dropped.
// CONFIGURATION
//  MDIO_CLAUSE45_EN defined: ST=2'b00 accepted; OP 00 address, 01 write (32-bit frames -> GAP);
//    OP 11 read, 10 read-post-increment (-> READ_TA after 14 bits); cmd[27:23]=PRTAD, cmd[22:18]=DEVAD.
//  MDIO_CLAUSE45_EN undefined: ST!=2'b01 -> command dropped at pop, st_err set, no MDIO activity.
// TESTING
//  Reset mid-preamble (rstn=0 one clk) -> next clk MDC=0, MDIO_T=1, busy=0, fifo_level=0.
//  Push 0x5082_1234 (C22 write PHY1 reg0) -> 32 ones then bits match 0x50821234 at rising MDC;
//    frame_done at clk 65*16 after pop.
//  Push 0x6086_0000 (C22 read reg1), PHY model drives 0x796D -> MDIO_T=1 from TA; 0x80 reads read_data=0x796D, addr=1.
//  Push 5 commands while busy, FIFO_DEPTH=4 -> 5th dropped, overflow=1; write 8'h01 -> overflow=0.
//  Push 0x0000_0000: without macro -> st_err=1, no MDC toggles; with MDIO_CLAUSE45_EN -> address frame sent.
//  PREAMBLE_BITS=0, CLK_DIV=2 -> no preamble, MDC period 4 clk, frame_done 33*4 clk after pop.

Source files
------------

// File: rtl/mdio_master_q.sv
// MDIO management master: command FIFO, programmable MDC divider and preamble, sticky error flags.
// Optional clause 45 framing (ST=2'b00) is compiled in when MDIO_CLAUSE45_EN is defined.
module mdio_master_q #(
  parameter int CLK_DIV       = 8,
  parameter int PREAMBLE_BITS = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_wen,
  input  logic [15:0] reg_raddr,
  output logic [31:0] reg_rdata,
  output logic        MDC,
  input  logic        MDIO_I,
  output logic        MDIO_O,
  output logic        MDIO_T,
  output logic        frame_done
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_SAMPLE = DW'(CLK_DIV - 1);
  localparam logic [5:0]    PRE_LAST   = 6'(PREAMBLE_BITS - 1);
  localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREAMBLE  = 3'd1,
    S_FRAME     = 3'd2,
    S_READ_TA   = 3'd3,
    S_READ_DATA = 3'd4,
    S_GAP       = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d, last_idx;
  logic [31:0]     cmd_q, cmd_d;
  logic            mdc_q, mdc_d, mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     read_data_q, read_data_d;
  logic [4:0]      read_reg_addr_q, read_reg_addr_d;
  logic            overflow_q, overflow_d, st_err_q, st_err_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_level;
  logic [31:0]     fifo_mem_q [FIFO_DEPTH];
  logic [31:0]     fifo_head;
  logic            fifo_empty, fifo_full, push_req, push, clr, pop, st_err_set;
  logic            unused_addr_bits;

  function automatic logic cmd_legal(input logic [31:0] c);
    logic ok;
    ok = (c[31:30] == 2'b01) && ((c[29:28] == 2'b01) || (c[29:28] == 2'b10));
`ifdef MDIO_CLAUSE45_EN
    ok = ok || (c[31:30] == 2'b00);
`endif
    return ok;
  endfunction

  function automatic logic cmd_is_read(input logic [31:0] c);
    logic rd;
    rd = (c[31:30] == 2'b01) && (c[29:28] == 2'b10);
`ifdef MDIO_CLAUSE45_EN
    rd = rd || ((c[31:30] == 2'b00) && c[29]);
`endif
    return rd;
  endfunction

  assign unused_addr_bits = ^{reg_waddr[15:8], reg_raddr[15:8]};

  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_FULL);
  assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign push_req   = reg_wen && (reg_waddr[7:0] == 8'h00);
  assign clr        = reg_wen && (reg_waddr[7:0] == 8'h01);
  // A full FIFO still accepts a push in the cycle the head is popped.
  assign push       = push_req && (!fifo_full || pop);
  assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
  assign overflow_d = (push_req && fifo_full && !pop) || (overflow_q && !clr);
  assign st_err_d   = st_err_set || (st_err_q && !clr);

  always_comb begin
    case (state_q)
      S_PREAMBLE:  last_idx = PRE_LAST;
      S_FRAME:     last_idx = cmd_is_read(cmd_q) ? 6'd13 : 6'd31;
      S_READ_TA:   last_idx = 6'd1;
      S_READ_DATA: last_idx = 6'd15;
      default:     last_idx = 6'd0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d         = state_q;
    div_cnt_d       = div_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    cmd_d           = cmd_q;
    mdio_o_d        = mdio_o_q;
    mdio_t_d        = mdio_t_q;
    frame_done_d    = 1'b0;
    read_data_d     = read_data_q;
    read_reg_addr_d = read_reg_addr_q;
    pop             = 1'b0;
    st_err_set      = 1'b0;

    if (state_q == S_IDLE) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      mdio_o_d  = 1'b1;
      mdio_t_d  = 1'b1;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (cmd_legal(fifo_head)) begin
          cmd_d    = fifo_head;
          mdio_t_d = 1'b0;
          state_d  = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_FRAME;
        end else begin
          st_err_set = 1'b1;
        end
      end
    end else begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;

      // Pin updates land as div_cnt becomes 1, well before the rising MDC edge.
      if (div_cnt_q == '0) begin
        case (state_q)
          S_PREAMBLE: mdio_o_d = 1'b1;
          S_FRAME:    mdio_o_d = cmd_q[~bit_cnt_q[4:0]];
          default: begin
            mdio_o_d = 1'b1;
            mdio_t_d = 1'b1;
          end
        endcase
      end

      if ((state_q == S_READ_DATA) && (div_cnt_q == DIV_SAMPLE))
        read_data_d = {read_data_q[14:0], MDIO_I};

      if (div_cnt_q == DIV_LAST) begin
        if (bit_cnt_q == last_idx) begin
          bit_cnt_d = '0;
          case (state_q)
            S_PREAMBLE:  state_d = S_FRAME;
            S_FRAME:     state_d = cmd_is_read(cmd_q) ? S_READ_TA : S_GAP;
            S_READ_TA: begin
              state_d         = S_READ_DATA;
              read_reg_addr_d = cmd_q[22:18];
            end
            S_READ_DATA: state_d = S_GAP;
            default: begin
              state_d      = S_IDLE;
              frame_done_d = 1'b1;
            end
          endcase
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end

    mdc_d = (state_d != S_IDLE) && (div_cnt_d >= DIV_HALF);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      div_cnt_q       <= '0;
      bit_cnt_q       <= '0;
      cmd_q           <= '0;
      mdc_q           <= 1'b0;
      mdio_o_q        <= 1'b1;
      mdio_t_q        <= 1'b1;
      frame_done_q    <= 1'b0;
      read_data_q     <= '0;
      read_reg_addr_q <= '0;
      overflow_q      <= 1'b0;
      st_err_q        <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      state_q         <= state_d;
      div_cnt_q       <= div_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      cmd_q           <= cmd_d;
      mdc_q           <= mdc_d;
      mdio_o_q        <= mdio_o_d;
      mdio_t_q        <= mdio_t_d;
      frame_done_q    <= frame_done_d;
      read_data_q     <= read_data_d;
      read_reg_addr_q <= read_reg_addr_d;
      overflow_q      <= overflow_d;
      st_err_q        <= st_err_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  // NOTE: command storage has no reset; the pointers define validity, so a flush only clears them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= reg_wdata;
  end

  always_comb begin
    case (reg_raddr[7:0])
      8'h80:   reg_rdata = {(state_q != S_IDLE), fifo_full, fifo_empty, overflow_q, st_err_q,
                            state_q, 3'd0, read_reg_addr_q, read_data_q};
      8'h81:   reg_rdata = {27'd0, 5'(fifo_level)};
      default: reg_rdata = 32'd0;
    endcase
  end

  assign MDC        = mdc_q;
  assign MDIO_O     = mdio_o_q;
  assign MDIO_T     = mdio_t_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mdio_master_q.sv
// Bench for mdio_master_q: vector table, randomized commands against a frame-level model,
// FIFO overflow / reset corner cases, and a second instance with no preamble and CLK_DIV=2.
module tb_mdio_master_q;

  localparam int CD = 8, PB = 32, FD = 4;
  localparam int FRAME_CLKS = (PB + 33) * 2 * CD;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] reg_waddr, reg_raddr;
  logic [31:0] reg_wdata, reg_rdata, reg_rdata2;
  logic        reg_wen, reg_wen2;
  logic        mdc, mdio_i, mdio_o, mdio_t, frame_done;
  logic        mdc2, mdio_i2, mdio_o2, mdio_t2, fd2;

  int          n_checks = 0, n_errors = 0;
  logic [1:0]  edges[$];
  logic [1:0]  exp_edges[$];
  int          rise_cnt = 0, rise_total = 0, clk_cnt = 0, done_cycles = 0, frames = 0;
  bit          in_frame = 1'b0, mdc_prev = 1'b0;
  logic [15:0] phy_data = '0;
  int          rise2 = 0, clk2 = 0, done2 = 0, frames2 = 0;
  bit          in2 = 1'b0, mdc2_prev = 1'b0;
  logic [31:0] word2 = '0;

  typedef struct {
    logic [31:0] cmd;
    logic [15:0] phy;
    bit          legal;
    bit          rd;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mdio_master_q #(.CLK_DIV(CD), .PREAMBLE_BITS(PB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .MDC(mdc), .MDIO_I(mdio_i), .MDIO_O(mdio_o),
    .MDIO_T(mdio_t), .frame_done(frame_done));

  mdio_master_q #(.CLK_DIV(2), .PREAMBLE_BITS(0), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rstn(rstn), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen2),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata2), .MDC(mdc2), .MDIO_I(mdio_i2), .MDIO_O(mdio_o2),
    .MDIO_T(mdio_t2), .frame_done(fd2));

  assign mdio_i2 = 1'b1;

  // PHY model: data bit k is presented for rising edge PB+16+k (after preamble, 14 header bits, TA).
  always_comb begin
    mdio_i = 1'b1;
    if (rise_cnt >= PB + 16 && rise_cnt < PB + 32) mdio_i = phy_data[4'(PB + 31 - rise_cnt)];
  end

  // Frame monitor: a frame starts when the line is claimed and ends at frame_done.
  always @(negedge clk) begin
    if (!rstn) begin
      in_frame = 1'b0;
      mdc_prev = 1'b0;
    end else begin
      if (mdc && !mdc_prev) begin
        rise_total++;
        if (in_frame) begin
          edges.push_back({mdio_t, mdio_o});
          rise_cnt++;
        end
      end
      if (in_frame) clk_cnt++;
      if (!in_frame && !mdio_t) begin
        in_frame = 1'b1;
        clk_cnt  = 0;
        rise_cnt = 0;
      end
      if (in_frame && frame_done) begin
        done_cycles = clk_cnt;
        frames++;
        in_frame = 1'b0;
      end
      mdc_prev = mdc;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      in2       = 1'b0;
      mdc2_prev = 1'b0;
    end else begin
      if (mdc2 && !mdc2_prev && in2) begin
        if (rise2 < 32) word2 = {word2[30:0], mdio_o2};
        rise2++;
      end
      if (in2) clk2++;
      if (!in2 && !mdio_t2) begin
        in2   = 1'b1;
        clk2  = 0;
        rise2 = 0;
      end
      if (in2 && fd2) begin
        done2 = clk2;
        frames2++;
        in2 = 1'b0;
      end
      mdc2_prev = mdc2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_legal(input logic [31:0] c);
    if (c[31:30] == 2'b01) return (c[29:28] == 2'b01) || (c[29:28] == 2'b10);
`ifdef MDIO_CLAUSE45_EN
    if (c[31:30] == 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit m_read(input logic [31:0] c);
    if (c[31:30] == 2'b01) return c[29:28] == 2'b10;
`ifdef MDIO_CLAUSE45_EN
    if (c[31:30] == 2'b00) return c[29];
`endif
    return 1'b0;
  endfunction

  // Expected {MDIO_T, MDIO_O} at each rising MDC; MDIO_O is ignored where MDIO_T=1.
  function automatic void build_expected(input logic [31:0] c, input bit rd);
    exp_edges.delete();
    for (int i = 0; i < PB; i++) exp_edges.push_back(2'b01);
    for (int i = 0; i < (rd ? 14 : 32); i++) exp_edges.push_back({1'b0, c[31-i]});
    if (rd) for (int i = 0; i < 18; i++) exp_edges.push_back(2'b10);
    exp_edges.push_back(2'b10);
  endfunction

  task automatic read_reg(input logic [15:0] a, output logic [31:0] d, output logic [31:0] d2);
    reg_raddr = a;
    #1;
    d  = reg_rdata;
    d2 = reg_rdata2;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_waddr = {8'h00, a};
    reg_wdata = d;
    reg_wen   = 1'b1;
    @(negedge clk);
    reg_wen   = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, 32'(frames >= target), 32'd1);
  endtask

  task automatic run_cmd(input logic [31:0] c, input logic [15:0] phy, input bit legal,
                         input bit rd, input string tag);
    int f0, r0, bad;
    logic [31:0] st, st2;
    phy_data = phy;
    f0 = frames;
    r0 = rise_total;
    edges.delete();
    write_reg(8'h00, c);
    if (legal) begin
      wait_frames(f0 + 1, FRAME_CLKS + 100, tag);
      build_expected(c, rd);
      check({tag, " len"}, done_cycles, FRAME_CLKS);
      check({tag, " nedges"}, edges.size(), exp_edges.size());
      bad = 0;
      for (int i = 0; i < exp_edges.size() && i < edges.size(); i++)
        if (edges[i][1] !== exp_edges[i][1] || (!exp_edges[i][1] && edges[i][0] !== exp_edges[i][0]))
          bad++;
      check({tag, " bits"}, bad, 0);
      read_reg(16'h0080, st, st2);
      check({tag, " idle"}, st[31], 1'b0);
      if (rd) begin
        check({tag, " rdata"}, st[15:0], phy);
        check({tag, " raddr"}, st[20:16], c[22:18]);
      end
    end else begin
      repeat (20) @(negedge clk);
      read_reg(16'h0080, st, st2);
      check({tag, " st_err"}, st[27], 1'b1);
      check({tag, " busy"}, st[31], 1'b0);
      check({tag, " no mdc"}, rise_total - r0, 0);
      write_reg(8'h01, 32'd0);
      read_reg(16'h0080, st, st2);
      check({tag, " st_err clr"}, st[27], 1'b0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] st, st2, c;
    int f0, r0, n;

    vecs[0] = '{32'h5082_1234, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{32'h6086_0000, 16'h796D, 1'b1, 1'b1};
    vecs[2] = '{32'h5FFF_FFFF, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{32'h6FFC_0000, 16'h8001, 1'b1, 1'b1};
    vecs[4] = '{32'h4000_0000, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{32'h7000_0000, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{32'hA000_0000, 16'h0000, 1'b0, 1'b0};
`ifdef MDIO_CLAUSE45_EN
    vecs[7] = '{32'h0000_0000, 16'h0000, 1'b1, 1'b0};
`else
    vecs[7] = '{32'h0000_0000, 16'h0000, 1'b0, 1'b0};
`endif

    rstn = 1'b0; reg_wen = 1'b0; reg_wen2 = 1'b0;
    reg_waddr = '0; reg_wdata = '0; reg_raddr = 16'h0080;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state and register decode
    check("rst mdc", mdc, 1'b0);
    check("rst mdio_o", mdio_o, 1'b1);
    check("rst mdio_t", mdio_t, 1'b1);
    check("rst frame_done", frame_done, 1'b0);
    read_reg(16'h0080, st, st2);
    check("rst status", st, 32'h2000_0000);
    read_reg(16'hAB80, st, st2);
    check("status hi addr", st, 32'h2000_0000);
    read_reg(16'h0081, st, st2);
    check("rst level", st, 32'd0);
    read_reg(16'h0042, st, st2);
    check("other addr", st, 32'd0);

    foreach (vecs[i]) run_cmd(vecs[i].cmd, vecs[i].phy, vecs[i].legal, vecs[i].rd,
                              $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      c = $urandom();
      if ($urandom_range(0, 3) != 0) c[31:30] = 2'b01;
      run_cmd(c, 16'($urandom()), m_legal(c), m_read(c), $sformatf("rnd%0d", i));
    end

    // Overflow: one frame in flight, five more pushed into a 4-deep FIFO
    f0 = frames;
    write_reg(8'h00, 32'h5082_0001);
    n = 0;
    do begin
      @(negedge clk);
      read_reg(16'h0080, st, st2);
      n++;
    end while (!st[31] && n < 20);
    check("ovf busy", st[31], 1'b1);
    for (int i = 0; i < 5; i++) write_reg(8'h00, 32'h5082_0010 + 32'(i));
    read_reg(16'h0081, st, st2);
    check("ovf level", st, 32'd4);
    read_reg(16'h0080, st, st2);
    check("ovf flag", st[28], 1'b1);
    check("ovf full", st[30], 1'b1);
    write_reg(8'h01, 32'd0);
    read_reg(16'h0080, st, st2);
    check("ovf clear", st[28], 1'b0);

    // Push lands on the same edge as the pop of a full FIFO
    n = 0;
    while (!frame_done && n < FRAME_CLKS + 100) begin
      @(negedge clk);
      n++;
    end
    check("pp frame_done", frame_done, 1'b1);
    reg_waddr = 16'h0000; reg_wdata = 32'h5082_0020; reg_wen = 1'b1;
    @(negedge clk);
    reg_wen = 1'b0;
    read_reg(16'h0081, st, st2);
    check("pp level", st, 32'd4);
    read_reg(16'h0080, st, st2);
    check("pp no ovf", st[28], 1'b0);
    wait_frames(f0 + 6, 6 * (FRAME_CLKS + 10), "drain");
    check("drain len", done_cycles, FRAME_CLKS);

    // Reset in the middle of the preamble, with commands still queued
    write_reg(8'h00, 32'h5082_1234);
    repeat (100) @(negedge clk);
    write_reg(8'h00, 32'h5082_1234);
    write_reg(8'h00, 32'h5082_1234);
    rstn = 1'b0;
    @(negedge clk);
    check("mid rst mdc", mdc, 1'b0);
    check("mid rst mdio_t", mdio_t, 1'b1);
    read_reg(16'h0080, st, st2);
    check("mid rst busy", st[31], 1'b0);
    read_reg(16'h0081, st, st2);
    check("mid rst level", st, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    r0 = rise_total;
    repeat (200) @(negedge clk);
    check("post rst quiet", rise_total - r0, 0);
    read_reg(16'h0080, st, st2);
    check("post rst status", st, 32'h2000_0000);

    // No preamble, CLK_DIV=2 instance
    f0 = frames2;
    @(negedge clk);
    reg_waddr = 16'h0000; reg_wdata = 32'h5082_1234; reg_wen2 = 1'b1;
    @(negedge clk);
    reg_wen2 = 1'b0;
    n = 0;
    while (frames2 == f0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("np done", 32'(frames2 > f0), 32'd1);
    check("np len", done2, 33 * 4);
    check("np rises", rise2, 33);
    check("np bits", word2, 32'h5082_1234);
    read_reg(16'h0081, st, st2);
    check("np level", st2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
